// File: rtl/alu_bus_arbiter_if.sv
// Request/grant bus between the processor masters and the ALU arbiter.
interface alu_bus_arbiter_if #(
    parameter int NumRequesters = 2
);
    localparam int IW = $clog2(NumRequesters);

    logic [NumRequesters-1:0] i_request;
    logic [NumRequesters-1:0] i_release;
    logic [NumRequesters-1:0] o_grant;
    logic [IW-1:0]            o_grant_index;
    logic                     o_busy;
    logic                     o_timeout;

    modport master (
        output i_request, i_release,
        input  o_grant, o_grant_index, o_busy, o_timeout
    );

    modport slave (
        input  i_request, i_release,
        output o_grant, o_grant_index, o_busy, o_timeout
    );
endinterface

// File: rtl/alu_bus_arbiter.sv
// Round-robin arbiter for the shared ALU behind the Spi link. A grantee keeps
// the link until it releases it or the watchdog expires; a short gap follows
// every grant so the Spi select line deasserts between owners.
module alu_bus_arbiter #(
    parameter int NumRequesters = 2,
    parameter int TimeoutCycles = 255,
    parameter int GapCycles     = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    alu_bus_arbiter_if.slave bus
);
    localparam int IW = $clog2(NumRequesters);
    localparam int CW = $clog2(TimeoutCycles);
    localparam int GW = $clog2(GapCycles + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(TimeoutCycles - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GapCycles - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NumRequesters - 1);
    localparam logic [IW:0]   N_WIDE  = (IW+1)'(NumRequesters);

    typedef enum logic [1:0] {IDLE, GRANTED, GAP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gap, gap_n;

    logic [NumRequesters-1:0] grant_n;
    logic [IW-1:0]            idx_n;
    logic                     busy_n;
    logic                     tmo_n;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW:0]   scan;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            scan = {1'b0, ptr} + (IW+1)'(i);
            if (scan >= N_WIDE) scan = scan - N_WIDE;
            if (!pick_found && bus.i_request[scan[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gap_n   = gap;
        grant_n = bus.o_grant;
        idx_n   = bus.o_grant_index;
        busy_n  = bus.o_busy;
        tmo_n   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_n = NumRequesters'(1) << pick_idx;
                    idx_n   = pick_idx;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = GRANTED;
                end
            end
            GRANTED: begin
                if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
                // Release is checked first so it beats a simultaneous timeout.
                if (bus.i_release[bus.o_grant_index] || cnt == CNT_MAX) begin
                    tmo_n   = !bus.i_release[bus.o_grant_index];
                    grant_n = '0;
                    busy_n  = 1'b0;
                    ptr_n   = (bus.o_grant_index == IDX_MAX) ? '0 : bus.o_grant_index + 1'b1;
                    gap_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (gap == GAP_MAX) state_n = IDLE;
                else                gap_n   = gap + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset overrides everything, including a live grant.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state             <= IDLE;
            ptr               <= '0;
            cnt               <= '0;
            gap               <= '0;
            bus.o_grant       <= '0;
            bus.o_grant_index <= '0;
            bus.o_busy        <= 1'b0;
            bus.o_timeout     <= 1'b0;
        end else begin
            state             <= state_n;
            ptr               <= ptr_n;
            cnt               <= cnt_n;
            gap               <= gap_n;
            bus.o_grant       <= grant_n;
            bus.o_grant_index <= idx_n;
            bus.o_busy        <= busy_n;
            bus.o_timeout     <= tmo_n;
        end
    end
endmodule
